// File: rtl/irq_req_prienc_arb.sv
// irq_req_prienc_arb: edge-captured sticky request arbiter (highest index wins) with valid/ack handshake.
// Ports: clk, rst (sync active-high); req[N] request lines; ack consumer accept;
//        idx granted index; valid grant outstanding; pending sticky request register;
//        overflow sticky re-request-while-pending flag.
// Optional: define REQ_MASK_EN to add input mask[N] (last port) that drops masked request edges.
module irq_req_prienc_arb #(
  parameter int IDXW = 2,
  localparam int N = 2 ** IDXW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            ack,
  output logic [IDXW-1:0] idx,
  output logic            valid,
  output logic [N-1:0]    pending,
  output logic            overflow
`ifdef REQ_MASK_EN
  ,
  input  logic [N-1:0]    mask
`endif
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t            r_state, w_state_nxt;
  logic [IDXW-1:0]   r_idx, w_idx_nxt, w_hi;
  logic [N-1:0]      r_pending, r_req_d, w_rise, w_clr;
  logic              r_ovf, w_ack_ok;
`ifdef REQ_MASK_EN
  assign w_rise = req & ~r_req_d & ~mask;
`else
  assign w_rise = req & ~r_req_d;
`endif
  assign w_ack_ok = (r_state == GRANT) && ack;
  assign w_clr    = w_ack_ok ? N'(1) << r_idx : '0;
  always_comb begin
    w_hi = '0;
    for (int i = 0; i < N; i++) if (r_pending[i]) w_hi = IDXW'(i);
  end
  // A grant is frozen until acked: no pre-emption by later, higher-priority rises.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (r_state == IDLE && |r_pending) begin
      w_state_nxt = GRANT;
      w_idx_nxt   = w_hi;
    end else if (w_ack_ok) w_state_nxt = IDLE;
  end
  // req_d resets to ones so lines held high through reset are not seen as edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_pending <= '0;
      r_req_d   <= '1;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      r_req_d   <= req;
      r_ovf     <= r_ovf | (|(w_rise & r_pending & ~w_clr));
    end
  end
  assign idx      = r_idx;
  assign valid    = (r_state == GRANT);
  assign pending  = r_pending;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_irq_req_prienc_arb.sv
// tb_irq_req_prienc_arb: directed bench with a behavioural reference model and literal spot checks.
module tb_irq_req_prienc_arb;
  localparam int N = 4;
  logic clk = 0, rst = 1, ack = 0;
  logic [N-1:0] req = '0, mask = '0;
  logic [1:0] idx;
  logic valid, overflow;
  logic [N-1:0] pending;
  int nvec = 0, nmis = 0;
  always #5 clk = ~clk;
  irq_req_prienc_arb #(.IDXW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .idx(idx), .valid(valid),
    .pending(pending), .overflow(overflow)
`ifdef REQ_MASK_EN
    , .mask(mask)
`endif
  );
  bit m_pend[N], m_prev[N], m_ovf, m_on;
  int m_gnt = -1;
  task automatic chk(string name, int act, int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  function automatic int pend_val();
    int v = 0;
    for (int i = 0; i < N; i++) if (m_pend[i]) v += 1 << i;
    return v;
  endfunction
  // Reference: a set of pending lines, the currently granted line (-1 = none), and a sticky flag.
  always @(posedge clk) begin
    if (rst) begin
      foreach (m_pend[i]) begin m_pend[i] = 0; m_prev[i] = 1; end
      m_gnt = -1; m_ovf = 0; m_on = 1;
    end else begin
      int served, top;
      bit rise;
      bit nxt[N];
      served = (m_gnt >= 0 && ack) ? m_gnt : -1;
      top = -1;
      for (int i = 0; i < N; i++) begin
        if (m_pend[i]) top = i;
        rise = req[i] && !m_prev[i];
`ifdef REQ_MASK_EN
        rise = rise && !mask[i];
`endif
        if (rise && m_pend[i] && i != served) m_ovf = 1;
        nxt[i] = rise || (m_pend[i] && i != served);
      end
      if (m_gnt >= 0) begin
        if (ack) m_gnt = -1;
      end else m_gnt = top;
      for (int i = 0; i < N; i++) begin m_pend[i] = nxt[i]; m_prev[i] = req[i]; end
    end
  end
  always @(negedge clk) if (m_on) begin
    chk("valid", int'(valid), int'(m_gnt >= 0));
    chk("pending", int'(pending), pend_val());
    chk("overflow", int'(overflow), int'(m_ovf));
    if (m_gnt >= 0) chk("idx", int'(idx), m_gnt);
  end
  task automatic cyc(input logic [N-1:0] r, input logic a = 0, input logic rs = 0);
    @(negedge clk);
    req = r; ack = a; rst = rs;
    @(posedge clk);
    #1;
  endtask
  initial begin
    cyc(4'b0100, 0, 1);
    cyc(4'b0100, 0, 1);
    chk("rst_idx", int'(idx), 0);
    chk("rst_valid", int'(valid), 0);
    repeat (5) cyc(4'b0100);
    chk("held_pending", int'(pending), 0);
    chk("held_valid", int'(valid), 0);
    cyc(4'b0000);
    cyc(4'b0100);
    chk("t1_pend", int'(pending), 4);
    chk("t1_valid_early", int'(valid), 0);
    cyc(4'b0100);
    chk("t1_valid", int'(valid), 1);
    chk("t1_idx", int'(idx), 2);
    cyc(4'b0100, 1);
    chk("t1_ack_valid", int'(valid), 0);
    cyc(4'b1010);
    cyc(4'b0000);
    chk("t2_idx3", int'(idx), 3);
    cyc(4'b0000, 1);
    chk("t2_gap_valid", int'(valid), 0);
    chk("t2_gap_pend", int'(pending), 2);
    cyc(4'b0000);
    chk("t2_idx1", int'(idx), 1);
    chk("t2_valid1", int'(valid), 1);
    cyc(4'b0000, 1);
    chk("t2_done_pend", int'(pending), 0);
    cyc(4'b0010);
    cyc(4'b0000);
    cyc(4'b1000);
    cyc(4'b0000);
    chk("t3_nopreempt", int'(idx), 1);
    chk("t3_pend", int'(pending), 10);
    cyc(4'b0000, 1);
    cyc(4'b0000);
    chk("t3_next", int'(idx), 3);
    cyc(4'b0000, 1);
    cyc(4'b0100);
    cyc(4'b0000);
    chk("t4_idx2", int'(idx), 2);
    cyc(4'b0100);
    chk("t4_ovf", int'(overflow), 1);
    chk("t4_pend", int'(pending), 4);
    cyc(4'b0000);
    cyc(4'b0100, 1);
    chk("t4_rise_wins", int'(pending), 4);
    chk("t4_ack_valid", int'(valid), 0);
    cyc(4'b0000);
    chk("t4_regrant", int'(idx), 2);
    chk("t4_regrant_v", int'(valid), 1);
    cyc(4'b0000, 1);
    chk("t4_ovf_sticky", int'(overflow), 1);
    cyc(4'b1101);
    cyc(4'b0000);
    chk("t5_pend", int'(pending), 13);
    chk("t5_idx", int'(idx), 3);
    cyc(4'b0000, 0, 1);
    chk("t5_rst_valid", int'(valid), 0);
    chk("t5_rst_pend", int'(pending), 0);
    chk("t5_rst_ovf", int'(overflow), 0);
    repeat (3) cyc(4'b0000, 1);
    chk("t5_idle_ack", int'(valid), 0);
`ifdef REQ_MASK_EN
    cyc(4'b0000);
    mask = 4'b1000;
    cyc(4'b1001);
    chk("t6_pend", int'(pending), 1);
    cyc(4'b1000);
    chk("t6_idx0", int'(idx), 0);
    cyc(4'b1000, 1);
    mask = 4'b0000;
    repeat (3) cyc(4'b1000);
    chk("t6_unmask_quiet", int'(valid), 0);
    cyc(4'b0000);
    cyc(4'b1000);
    cyc(4'b0000);
    chk("t6_idx3", int'(idx), 3);
    cyc(4'b0000, 1);
`endif
    cyc(4'b0000);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/irq_req_prienc_arb.md
Name: irq_req_prienc_arb

Overview:
- Sequential front end that sits directly upstream of the team's combinational priority encoders.
- Captures rising edges on N request lines into a sticky pending register.
- Presents the highest-priority pending index to the consumer with a valid/ack handshake.
- Clears the served bit on ack.
- Highest index wins, the same priority order as the encoder stage (i[1] beats i[0]).

Parameters:
- IDXW, 2, width of the index output; N = 2**IDXW request lines (default 4).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request lines; a 0->1 transition between consecutive clk samples is one request.
- ack  input  1  consumer accepts the presented index; sampled only in GRANT.
- idx  output  IDXW  index of the granted request; meaningful only while valid=1.
- valid  output  1  idx holds a granted request awaiting ack.
- pending  output  N  current pending register (debug/status).
- overflow  output  1  sticky; a request edge arrived on a line that was already pending.

Behaviour:
- Reset (rst=1 at a clk edge):
  - pending=0, idx=0, valid=0, overflow=0, FSM=IDLE.
  - req_d (previous-sample register) is loaded with all ones, so a line held high through reset is NOT captured.
  - The line must drop and rise again to be captured.
- Edge detect: rise = req & ~req_d; req_d <= req every cycle.
- Pending update each cycle: pending <= (pending & ~clr) | rise.
  - clr is the one-hot of idx when ack is accepted in GRANT; 0 otherwise.
  - Simultaneous rise and clr on the same line: rise wins, the bit stays set, overflow is not raised.
- overflow: set when (rise & pending & ~clr) != 0; held until reset.
- FSM, two states:
  - IDLE: valid=0. If pending != 0, idx <= index of the highest set pending bit, valid <= 1, go to GRANT. If pending == 0, stay. ack is ignored.
  - GRANT: idx and valid are held stable regardless of new rises, including higher-priority rises (no pre-emption). On ack=1: clr applied, valid <= 0, go to IDLE. On ack=0: stay.
- Latency:
  - req first sampled high at edge t -> pending bit set after t -> valid=1 after edge t+1 (when in IDLE).
  - ack sampled at edge g -> valid=0 after g. The next grant is available after g+1; there is always one IDLE cycle between grants.
- Back-to-back: with requests on lines 3 and 1 pending, lines are granted as 3 then 1, each needing its own ack.
- A line re-requesting (new edge) while granted and not yet acked: no second pending entry; overflow=1.
- Reset mid-GRANT: valid drops after the reset edge and all pending requests are discarded.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: REQ_MASK_EN.
- Defined:
  - Adds input port mask, width N, as the last port.
  - rise is gated: rise = req & ~req_d & ~mask. Masked edges are dropped and never become pending.
  - Already-pending bits are unaffected by mask and are still granted.
  - Masked edges never set overflow.
- Undefined: no mask port; behaviour exactly as above.

Test Plan:
1. Reset with req=4'b0100 held high, then release rst -> pending stays 0 and valid stays 0 for 5 cycles. Drop req[2] and raise it again -> valid=1, idx=2 two edges after the rise.
2. Pulse req=4'b1010 in one cycle -> grant idx=3. Ack -> valid=0 for one cycle, then idx=1 with valid=1. Ack -> pending=0, valid=0.
3. In GRANT with idx=1, raise req[3] -> idx stays 1 until ack. The next grant is idx=3.
4. In GRANT idx=2, re-pulse req[2] before ack -> overflow=1 and pending[2] stays 1. Ack the same cycle as a further rise on req[2] -> pending[2] stays 1, a re-grant of idx=2 follows, and overflow stays 1 until rst.
5. Assert rst during GRANT with pending=4'b1101 -> after the edge: valid=0, pending=0, overflow=0. ack=1 held in IDLE has no effect.
6. (REQ_MASK_EN) mask=4'b1000, pulse req=4'b1001 -> only idx=0 granted and pending[3]=0. Clearing the mask afterwards grants nothing until a new edge on req[3].
